ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard.
- Pairs with the existing PS/2 receive interface on the same open-collector ps2_clock/ps2_data pins.
- Top level drives each pin low when the matching *_oe output is high, and releases (Z) otherwise.
- The receive path must ignore bus traffic while busy is high.

---
 rtl/ps2_host_tx.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter.
// Define PS2_HOST_TX_RETRY_EN to retransmit on missing ACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

`ifdef PS2_HOST_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t          r_state;
  logic            r_clk_s1;
  logic            r_clk_s2;
  logic            r_clk_prev;
  logic            r_dat_s1;
  logic            r_dat_s2;
  logic [IW-1:0]   r_inh_cnt;
  logic [TW-1:0]   r_tmo;
  logic [3:0]      r_bit_cnt;
  logic [9:0]      r_frame;
  logic [7:0]      r_byte;
  logic            r_ack;
  logic [RW-1:0]   r_retry;

  logic            w_fall;
  logic            w_accept;
  logic            w_timed;
  logic            w_tmo_fire;
  logic            w_can_retry;
  logic            w_bus_idle;
  logic [9:0]      w_frame;
  logic [9:0]      w_reload;

  assign w_fall      = r_clk_prev & ~r_clk_s2;
  assign w_accept    = tx_valid & tx_ready;
  assign w_bus_idle  = r_clk_s2 & r_dat_s2;
  assign w_timed     = (r_state == S_RTS) || (r_state == S_SHIFT) ||
                       (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  // A fall in the same cycle as terminal count keeps the frame alive
  assign w_tmo_fire  = w_timed & ~w_fall & (r_tmo == TMO_LAST);
  assign w_can_retry = RETRY_EN && (r_retry < RTY_MAX);
  assign w_frame     = {1'b1, ~^tx_data, tx_data};
  assign w_reload    = {1'b1, ~^r_byte, r_byte};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_clk_s1    <= 1'b0;
      r_clk_s2    <= 1'b0;
      r_clk_prev  <= 1'b0;
      r_dat_s1    <= 1'b0;
      r_dat_s2    <= 1'b0;
      r_inh_cnt   <= '0;
      r_tmo       <= '0;
      r_bit_cnt   <= '0;
      r_frame     <= '0;
      r_byte      <= '0;
      r_ack       <= 1'b0;
      r_retry     <= '0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_ack_ok   <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data_in;
      r_dat_s2   <= r_dat_s1;
      tx_done    <= 1'b0;
      tx_ack_ok  <= 1'b0;
      tx_error   <= 1'b0;

      if (w_timed) begin
        r_tmo <= w_fall ? '0 : r_tmo + TW'(1);
      end

      if (w_tmo_fire) begin
        if (w_can_retry) begin
          r_retry     <= r_retry + RW'(1);
          r_frame     <= w_reload;
          r_inh_cnt   <= '0;
          ps2_clk_oe  <= 1'b1;
          ps2_data_oe <= 1'b0;
          r_state     <= S_INHIBIT;
        end else begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_error    <= 1'b1;
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_byte      <= tx_data;
              r_frame     <= w_frame;
              r_retry     <= '0;
              r_inh_cnt   <= '0;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              tx_ready    <= 1'b0;
              busy        <= 1'b1;
              r_state     <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            r_inh_cnt <= r_inh_cnt + IW'(1);
            if (r_inh_cnt == INH_PRE) begin
              ps2_data_oe <= 1'b1;
            end
            if (r_inh_cnt == INH_LAST) begin
              ps2_clk_oe <= 1'b0;
              r_bit_cnt  <= '0;
              r_tmo      <= '0;
              r_state    <= S_RTS;
            end
          end
          S_RTS, S_SHIFT: begin
            if (w_fall) begin
              ps2_data_oe <= ~r_frame[0];
              r_frame     <= {1'b0, r_frame[9:1]};
              r_bit_cnt   <= r_bit_cnt + 4'd1;
              r_state     <= (r_bit_cnt == 4'd9) ? S_ACK : S_SHIFT;
            end
          end
          S_ACK: begin
            if (w_fall) begin
              r_ack   <= ~r_dat_s2;
              r_state <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (w_bus_idle) begin
              if (!r_ack && w_can_retry) begin
                r_retry     <= r_retry + RW'(1);
                r_frame     <= w_reload;
                r_inh_cnt   <= '0;
                ps2_clk_oe  <= 1'b1;
                ps2_data_oe <= 1'b0;
                r_state     <= S_INHIBIT;
              end else begin
                tx_done   <= 1'b1;
                tx_ack_ok <= r_ack;
                tx_error  <= ~r_ack & RETRY_EN;
                r_state   <= S_DONE;
              end
            end
          end
          S_DONE: begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device model on the open-collector pins plus a
// cycle-count model of the host timing, random bytes and responses.
module tb_ps2_host_tx;

  localparam int N    = 50;
  localparam int T    = 400;
  localparam int MAXR = 2;

`ifdef PS2_HOST_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       busy;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_error;

  logic dev_clk = 1'b0;
  logic dev_dat = 1'b0;
  logic clk_pin;
  logic data_pin;

  assign clk_pin  = ~(ps2_clk_oe | dev_clk);
  assign data_pin = ~(ps2_data_oe | dev_dat);

  ps2_host_tx #(
    .INHIBIT_CYCLES(N),
    .TIMEOUT_CYCLES(T),
    .MAX_RETRIES(MAXR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .busy(busy),
    .ps2_clk_in(clk_pin),
    .ps2_data_in(data_pin),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done(tx_done),
    .tx_ack_ok(tx_ack_ok),
    .tx_error(tx_error)
  );

  always #10 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // model state
  int mode     = M_ACK;
  int k        = 0;
  bit in_frame = 1'b0;
  bit ended    = 1'b0;
  bit post     = 1'b0;
  bit mon_en   = 1'b0;

  // device state
  int         dev_mode   = M_ACK;
  int         dev_h      = 10;
  int         dev_frames = 0;
  int         dev_rises  = 0;
  bit         dev_busy   = 1'b0;
  logic       dev_start  = 1'b1;
  logic [9:0] dev_vec    = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2) == 0;
    return {1'b1, p, b};
  endfunction

  // Keyboard: answers each request-to-send with 11 clocks
  initial begin : device
    forever begin
      @(posedge clock);
      if (ps2_clk_oe) begin
        while (ps2_clk_oe || data_pin) @(posedge clock);
        dev_frames++;
        dev_rises = 0;
        dev_start = data_pin;
        dev_busy  = 1'b1;
        if (dev_mode != M_SILENT) begin
          repeat (3 + $urandom_range(0, 20)) @(posedge clock);
          for (int i = 0; i < 11; i++) begin
            #1 dev_clk = 1'b1;
            repeat (dev_h) @(posedge clock);
            #1;
            if (i < 10) dev_vec[i] = data_pin;
            dev_clk = 1'b0;
            dev_rises++;
            if (i == 9 && dev_mode == M_ACK) dev_dat = 1'b1;
            repeat (dev_h) @(posedge clock);
          end
          #1 dev_dat = 1'b0;
        end
        dev_busy = 1'b0;
      end
    end
  end

  // Cycle model: k counts cycles since the accepting edge
  always @(negedge clock) begin
    if (mon_en) begin
      if (post) begin
        chk("ready_after_end", tx_ready, 1);
        post = 1'b0;
      end
      if (in_frame) begin
        if (tx_done || tx_error) begin
          chk("tx_done", tx_done, mode != M_SILENT);
          chk("tx_error", tx_error,
              mode == M_SILENT || (RETRY && mode == M_NOACK));
          if (tx_done) chk("tx_ack_ok", tx_ack_ok, mode == M_ACK);
          if (!RETRY && mode == M_SILENT) chk("timeout_cycle", k, N + T);
          if (!tx_done) begin
            chk("err_clk_oe", ps2_clk_oe, 0);
            chk("err_data_oe", ps2_data_oe, 0);
          end
          in_frame = 1'b0;
          ended    = 1'b1;
          post     = 1'b1;
        end else begin
          chk("busy", busy, 1);
          chk("ready", tx_ready, 0);
          chk("ack_ok_idle", tx_ack_ok, 0);
          if (k < N) begin
            chk("inhibit_clk_oe", ps2_clk_oe, 1);
            chk("inhibit_data_oe", ps2_data_oe, k == N - 1);
          end else if (k == N) begin
            chk("rts_clk_oe", ps2_clk_oe, 0);
            chk("rts_data_oe", ps2_data_oe, 1);
          end else if (!RETRY) begin
            chk("shift_clk_oe", ps2_clk_oe, 0);
          end
          k++;
        end
      end else begin
        chk("idle_ready", tx_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", tx_done, 0);
        chk("idle_error", tx_error, 0);
        chk("idle_clk_oe", ps2_clk_oe, 0);
        chk("idle_data_oe", ps2_data_oe, 0);
      end
    end
  end

  task automatic recover();
    mon_en   = 1'b0;
    in_frame = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;
  endtask

  task automatic wait_dev_idle();
    int n;
    n = 0;
    while (dev_busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (dev_busy) begin
      compared++;
      mismatched++;
      $display("FAIL device_idle: device still busy after %0d cycles", n);
    end
  endtask

  task automatic send(input logic [7:0] b, input int m, input int h,
                      input bit hold);
    int n;
    @(negedge clock);
    chk("ready_before_send", tx_ready, 1);
    mode       = m;
    dev_mode   = m;
    dev_h      = h;
    dev_frames = 0;
    dev_vec    = '0;
    ended      = 1'b0;
    tx_data    = b;
    tx_valid   = 1'b1;
    @(posedge clock);
    #1;
    in_frame = 1'b1;
    k        = 0;
    if (hold) tx_data = 8'h00;
    else tx_valid = 1'b0;
    n = 0;
    while (!ended && n < 8000) begin
      @(negedge clock);
      n++;
    end
    tx_valid = 1'b0;
    if (!ended) begin
      compared++;
      mismatched++;
      $display("FAIL frame_end: no done/error within %0d cycles", n);
      recover();
    end
    wait_dev_idle();
    chk("frames_sent", dev_frames,
        (m == M_ACK) ? 1 : (RETRY ? MAXR + 1 : 1));
    chk("start_bit", dev_start, 0);
    if (m != M_SILENT) chk("frame_bits", dev_vec, frame_of(b));
  endtask

  initial begin : main
    int n;
    int m;
    logic [7:0] b;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_error", tx_error, 0);
    reset = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;

    send(8'hED, M_ACK, 20, 1'b0);
    chk("ed_literal", dev_vec, 10'h3ED);
    send(8'hF4, M_ACK, 15, 1'b0);
    chk("f4_literal", dev_vec, 10'h2F4);
    send(8'($urandom), M_NOACK, 10, 1'b0);
    send(8'($urandom), M_SILENT, 10, 1'b0);

    // reset after four data bits
    @(negedge clock);
    mode      = M_ACK;
    dev_mode  = M_ACK;
    dev_h     = 12;
    dev_rises = 0;
    tx_data   = 8'($urandom);
    tx_valid  = 1'b1;
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    in_frame = 1'b1;
    k        = 0;
    n        = 0;
    while (dev_rises < 4 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (dev_rises < 4) begin
      compared++;
      mismatched++;
      $display("FAIL abort_reach: only %0d device clocks", dev_rises);
    end
    mon_en   = 1'b0;
    in_frame = 1'b0;
    reset    = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_clk_oe", ps2_clk_oe, 0);
    chk("abort_data_oe", ps2_data_oe, 0);
    chk("abort_ready", tx_ready, 1);
    chk("abort_done", tx_done, 0);
    chk("abort_error", tx_error, 0);
    reset = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;
    wait_dev_idle();
    send(8'hFF, M_ACK, 18, 1'b0);
    chk("ff_literal", dev_vec, 10'h3FF);

    // valid held with 0x00 during a frame
    send(8'hED, M_ACK, 9, 1'b1);
    chk("hold_literal", dev_vec, 10'h3ED);
    repeat (20) @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      n = int'($urandom_range(0, 7));
      m = (n == 6) ? M_NOACK : (n == 7) ? M_SILENT : M_ACK;
      send(b, m, int'($urandom_range(8, 25)), 1'b0);
    end

    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
